lsu_byte_sequencer: RTL and testbench

LSU_BYTE_SEQUENCER -- requirements
Module: lsu_byte_sequencer

---
 rtl/lsu_byte_sequencer.sv | 124 ++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: splits one 32-bit word load/store into four byte beats on a
// byte-wide data memory. The beats go out little-endian, starting at the base
// address. For loads, the returned bytes are assembled into a word that is
// presented with a one-cycle completion pulse.
//
// Request handshake: a request is accepted on a rising clk_i edge where both
// req_valid_i and req_ready_o are high. req_ready_o is high only while the
// sequencer is idle. req_* inputs are sampled only on an accepting edge, so the
// requester may change or hold them freely at any other time.
module lsu_byte_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [7:0]        mem_rdata_i,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [23:0]       rdata_q;      // load bytes 0..2; byte 3 goes straight to resp_rdata_q
    logic [31:0]       resp_rdata_q;
    logic [7:0]        beat_wbyte;

    // Control FSM, beat counter, request capture and load-data assembly.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            rdata_q      <= 24'd0;
            resp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= 2'd0;
                        rdata_q <= 24'd0;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!write_q) begin
                        case (cnt_q)
                            2'd0:    rdata_q[7:0]   <= mem_rdata_i;
                            2'd1:    rdata_q[15:8]  <= mem_rdata_i;
                            2'd2:    rdata_q[23:16] <= mem_rdata_i;
                            default: rdata_q        <= rdata_q;
                        endcase
                    end
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Last beat: the final load byte is folded in on the same edge.
                        resp_rdata_q <= write_q ? 32'd0 : {mem_rdata_i, rdata_q};
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Little-endian byte select of the store word for the current beat.
    always_comb begin
        beat_wbyte = 8'd0;
        case (cnt_q)
            2'd0: beat_wbyte = wdata_q[7:0];
            2'd1: beat_wbyte = wdata_q[15:8];
            2'd2: beat_wbyte = wdata_q[23:16];
            2'd3: beat_wbyte = wdata_q[31:24];
            default: beat_wbyte = 8'd0;
        endcase
    end

    // Memory-side outputs are driven only during XFER and are forced to zero otherwise.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = 8'd0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        if (state_q == ST_XFER) begin
            mem_addr_o  = addr_q + ADDR_W'(cnt_q);
            mem_write_o = write_q;
            mem_read_o  = !write_q;
            mem_wdata_o = write_q ? beat_wbyte : 8'd0;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q == ST_XFER) || (state_q == ST_RESP);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = resp_rdata_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: a byte memory model, a request driver, and a
// negedge monitor that checks every beat and response against expected queues.
module tb_lsu_byte_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        busy_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [7:0]  mem_rdata_i;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // expected beats
    int          exp_cyc_q[$];
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_wdata_q[$];
    logic [1:0]  exp_strb_q[$];   // {write, read}
    // expected responses
    int          exp_rcyc_q[$];
    logic [31:0] exp_q[$];

    // byte memory model, indexed by the low address byte
    logic [7:0] mem [0:255];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = 8'd0;
    logic [7:0] pre_data = 8'd0;

    lsu_byte_sequencer #(.ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .busy_o       (busy_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_write_o  (mem_write_o),
        .mem_read_o   (mem_read_o),
        .mem_rdata_i  (mem_rdata_i),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // memory: preload port has priority, then DUT writes
    always @(posedge clk_i) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_write_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end

    assign mem_rdata_i = mem[mem_addr_o[7:0]];

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_missed: expected beat at cycle %0d addr %h not seen", exp_cyc_q[0], exp_addr_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_addr_q.pop_front());
            void'(exp_wdata_q.pop_front());
            void'(exp_strb_q.pop_front());
        end
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            check("beat_addr", mem_addr_o, exp_addr_q[0]);
            check("beat_wdata", {24'd0, mem_wdata_o}, {24'd0, exp_wdata_q[0]});
            check("beat_strobes", {30'd0, mem_write_o, mem_read_o}, {30'd0, exp_strb_q[0]});
            void'(exp_cyc_q.pop_front());
            void'(exp_addr_q.pop_front());
            void'(exp_wdata_q.pop_front());
            void'(exp_strb_q.pop_front());
        end else begin
            check("idle_strobes", {30'd0, mem_write_o, mem_read_o}, 32'd0);
            check("idle_addr", mem_addr_o, 32'd0);
            check("idle_wdata", {24'd0, mem_wdata_o}, 32'd0);
        end

        if (exp_rcyc_q.size() > 0 && exp_rcyc_q[0] < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_missed: expected response at cycle %0d not seen", exp_rcyc_q[0]);
            void'(exp_rcyc_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (exp_rcyc_q.size() > 0 && exp_rcyc_q[0] == cyc) begin
            check("resp_valid", {31'd0, resp_valid_o}, 32'd1);
            check("resp_rdata", resp_rdata_o, exp_q[0]);
            void'(exp_rcyc_q.pop_front());
            void'(exp_q.pop_front());
        end else begin
            check("resp_valid_quiet", {31'd0, resp_valid_o}, 32'd0);
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk_i);
        pre_we   = 1'b0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit hold, output int t);
        logic [31:0] wd;
        wd = d;
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o) break;
            @(negedge clk_i);
        end
        if (!req_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready_o never rose for addr %h", a);
            req_valid_i = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_cyc_q.push_back(t + 1 + k);
            exp_addr_q.push_back(a + 32'(k));
            exp_wdata_q.push_back(w ? wd[8*k +: 8] : 8'd0);
            exp_strb_q.push_back(w ? 2'b10 : 2'b01);
        end
        exp_rcyc_q.push_back(t + 5);
        exp_q.push_back(w ? 32'd0 : exp_rd);
        @(negedge clk_i);
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (exp_cyc_q.size() == 0 && exp_rcyc_q.size() == 0) break;
            @(negedge clk_i);
        end
        if (exp_cyc_q.size() != 0 || exp_rcyc_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: %0d beats and %0d responses outstanding", exp_cyc_q.size(), exp_rcyc_q.size());
        end
        @(negedge clk_i);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int t1;
        int t2;
        @(negedge clk_i);
        // preload memory while the DUT is held in reset
        poke(8'h04, 8'h00); poke(8'h05, 8'h00); poke(8'h06, 8'h00); poke(8'h07, 8'h00);
        poke(8'h08, 8'hAA); poke(8'h09, 8'hBB); poke(8'h0A, 8'hCC); poke(8'h0B, 8'hDD);
        poke(8'hFE, 8'h12); poke(8'hFF, 8'h34); poke(8'h00, 8'h56); poke(8'h01, 8'h78);

        // reset held with a pending request: nothing may be accepted
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h4;
        req_wdata_i = 32'hDEADBEEF;
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_resp_rdata", resp_rdata_o, 32'd0);
        check("rst_state", {30'd0, dbg_state_o}, 32'd0);

        // release and store 0xDEADBEEF to 0x4: accepted on the first edge
        rst_i = 1'b1;
        send(1'b1, 32'h4, 32'hDEADBEEF, 32'd0, 1'b0, t);
        wait_done();
        check("store_resp_hold", resp_rdata_o, 32'd0);
        check("store_mem_word", {mem[8'h07], mem[8'h06], mem[8'h05], mem[8'h04]}, 32'hDEADBEEF);

        // load it back
        send(1'b0, 32'h4, 32'd0, 32'hDEADBEEF, 1'b0, t);
        wait_done();
        check("load_resp_hold", resp_rdata_o, 32'hDEADBEEF);
        check("idle_ready", {31'd0, req_ready_o}, 32'd1);

        // wrap-around load from 0xFFFFFFFE
        send(1'b0, 32'hFFFF_FFFE, 32'd0, 32'h78563412, 1'b0, t);
        wait_done();

        // misaligned load from 0x5
        send(1'b0, 32'h5, 32'd0, 32'hAADEADBE, 1'b0, t);
        wait_done();

        // valid held high across two requests: store then load at 0x20
        send(1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b1, t1);
        for (int k = 1; k <= 5; k++) begin
            check("hold_ready_low", {31'd0, req_ready_o}, 32'd0);
            check("hold_busy_high", {31'd0, busy_o}, 32'd1);
            @(negedge clk_i);
        end
        send(1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0, t2);
        check("accept_spacing", t2, t1 + 6);
        wait_done();

        // store to 0x8 aborted by reset during beat 2
        send(1'b1, 32'h8, 32'h11223344, 32'd0, 1'b0, t);
        @(negedge clk_i);
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check("abort_write_drop", {31'd0, mem_write_o}, 32'd0);
        check("abort_read_low", {31'd0, mem_read_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_ready", {31'd0, req_ready_o}, 32'd1);
        check("abort_addr", mem_addr_o, 32'd0);
        exp_cyc_q.delete();
        exp_addr_q.delete();
        exp_wdata_q.delete();
        exp_strb_q.delete();
        exp_rcyc_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        check("abort_mem8", {24'd0, mem[8'h08]}, 32'h44);
        check("abort_mem9", {24'd0, mem[8'h09]}, 32'h33);
        check("abort_memA", {24'd0, mem[8'h0A]}, 32'hCC);
        check("abort_memB", {24'd0, mem[8'h0B]}, 32'hDD);
        check("abort_resp_rdata", resp_rdata_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // recovery: load the partially written word
        send(1'b0, 32'h8, 32'd0, 32'hDDCC3344, 1'b0, t);
        wait_done();
        repeat (2) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
